// File: rtl/decode_scoreboard_pkg.sv
// Shared definitions for the decode scoreboard: register-file geometry,
// the scoreboard FSM state encoding and a saturating-counter helper.
package decode_scoreboard_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int REG_COUNT   = 32;
  localparam int STALL_CNT_W = 16;

  // FLUSH lasts this value + 1 cycles
  localparam logic [1:0] FLUSH_LEN_M1 = 2'd1;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_COUNT-1:0]  reg_vec_t;

  typedef enum logic [1:0] {
    SB_RUN   = 2'd0,
    SB_STALL = 2'd1,
    SB_FLUSH = 2'd2
  } sb_state_e;

  function automatic logic [STALL_CNT_W-1:0] sat_inc16(input logic [STALL_CNT_W-1:0] v);
    logic [STALL_CNT_W-1:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/decode_scoreboard_if.sv
// Decode/write-back/exception bundle between the decode stage and the
// scoreboard; the scoreboard uses the slave side.
interface decode_scoreboard_if;
  import decode_scoreboard_pkg::*;

  logic                   issue_valid;
  reg_addr_t              issue_src1_addr;
  reg_addr_t              issue_src2_addr;
  logic                   issue_use_src2;
  reg_addr_t              issue_rd_addr;
  logic                   issue_writes_rd;
  logic                   issue_is_load;
  logic                   wb_valid;
  reg_addr_t              wb_addr;
  logic                   xcpt_valid;
  logic                   stall_decode;
  reg_vec_t               busy_vec;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output issue_valid, issue_src1_addr, issue_src2_addr, issue_use_src2,
    output issue_rd_addr, issue_writes_rd, issue_is_load,
    output wb_valid, wb_addr, xcpt_valid,
    input  stall_decode, busy_vec, stall_count
  );

  modport slave (
    input  issue_valid, issue_src1_addr, issue_src2_addr, issue_use_src2,
    input  issue_rd_addr, issue_writes_rd, issue_is_load,
    input  wb_valid, wb_addr, xcpt_valid,
    output stall_decode, busy_vec, stall_count
  );

endinterface

// File: rtl/decode_scoreboard.sv
// Register scoreboard for the decode stage: tracks pending writes, stalls on
// RAW hazards and flushes on exceptions. DECODE_SCOREBOARD_BYPASS_EN enables ALU bypass.
module decode_scoreboard
  import decode_scoreboard_pkg::*;
(
  input logic                clock,
  input logic                reset,
  decode_scoreboard_if.slave sb
);

  sb_state_e              state_q, state_d;
  logic [1:0]             flush_cnt_q, flush_cnt_d;
  reg_vec_t               busy_q, busy_d;
  reg_vec_t               load_q, load_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  reg_vec_t               pend_s;
  logic                   hazard_s;
  logic                   stall_s;
  logic                   accept_s;

  // Which registers count as not-yet-available to a consumer
  always_comb begin
`ifdef DECODE_SCOREBOARD_BYPASS_EN
    pend_s = busy_q & load_q;
`else
    pend_s = busy_q;
`endif
  end

  // RAW hazard comparator; same-cycle write-backs are deliberately ignored
  always_comb begin
    hazard_s = 1'b0;
    if (sb.issue_valid) begin
      hazard_s = pend_s[sb.issue_src1_addr] |
                 (sb.issue_use_src2 & pend_s[sb.issue_src2_addr]);
    end else begin
      hazard_s = 1'b0;
    end
  end

  // Stall request and issue acceptance
  always_comb begin
    stall_s  = hazard_s | (state_q == SB_FLUSH);
    accept_s = sb.issue_valid & ~stall_s;
  end

  // Busy/load next state: flush beats everything, a set beats a clear
  always_comb begin
    busy_d = busy_q;
    load_d = load_q;
    if (sb.xcpt_valid) begin
      busy_d = {REG_COUNT{1'b0}};
      load_d = {REG_COUNT{1'b0}};
    end else begin
      if (sb.wb_valid) begin
        busy_d[sb.wb_addr] = 1'b0;
        load_d[sb.wb_addr] = 1'b0;
      end else begin
        busy_d = busy_q;
      end
      if (accept_s && sb.issue_writes_rd) begin
        busy_d[sb.issue_rd_addr] = 1'b1;
        load_d[sb.issue_rd_addr] = sb.issue_is_load;
      end else begin
        load_d = load_d;
      end
    end
  end

  // FSM next state and flush countdown
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (sb.xcpt_valid) begin
      state_d     = SB_FLUSH;
      flush_cnt_d = FLUSH_LEN_M1;
    end else begin
      case (state_q)
        SB_RUN, SB_STALL: begin
          state_d     = hazard_s ? SB_STALL : SB_RUN;
          flush_cnt_d = 2'd0;
        end
        SB_FLUSH: begin
          if (flush_cnt_q != 2'd0) begin
            flush_cnt_d = flush_cnt_q - 2'd1;
          end else begin
            state_d     = SB_RUN;
            flush_cnt_d = 2'd0;
          end
        end
        default: begin
          state_d     = SB_RUN;
          flush_cnt_d = 2'd0;
        end
      endcase
    end
  end

  // Saturating stalled-cycle counter
  always_comb begin
    if (stall_s) begin
      stall_cnt_d = sat_inc16(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= SB_RUN;
      flush_cnt_q <= 2'd0;
      busy_q      <= {REG_COUNT{1'b0}};
      load_q      <= {REG_COUNT{1'b0}};
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      busy_q      <= busy_d;
      load_q      <= load_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign sb.stall_decode = stall_s;
  assign sb.busy_vec     = busy_q;
  assign sb.stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed bench for decode_scoreboard: a vector table for the single-cycle
// behaviour plus hand sequences for bypass, saturation and async reset.
module tb_decode_scoreboard;
  import decode_scoreboard_pkg::*;

`ifdef DECODE_SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock;
  logic reset;
  int   total;
  int   bad;

  decode_scoreboard_if sb_if();

  decode_scoreboard dut (
    .clock (clock),
    .reset (reset),
    .sb    (sb_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        iv;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic        u2;
    logic [4:0]  rd;
    logic        wr;
    logic        ld;
    logic        wv;
    logic [4:0]  wa;
    logic        xv;
    logic        es;
    logic [31:0] eb;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl [27];

  function automatic vec_t mk(input logic iv, input logic [4:0] s1, input logic [4:0] s2,
                              input logic u2, input logic [4:0] rd, input logic wr,
                              input logic ld, input logic wv, input logic [4:0] wa,
                              input logic xv, input logic es, input logic [31:0] eb,
                              input logic [15:0] ec);
    vec_t v;
    v.iv = iv; v.s1 = s1; v.s2 = s2; v.u2 = u2; v.rd = rd; v.wr = wr; v.ld = ld;
    v.wv = wv; v.wa = wa; v.xv = xv; v.es = es; v.eb = eb; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    sb_if.issue_valid     = v.iv;
    sb_if.issue_src1_addr = v.s1;
    sb_if.issue_src2_addr = v.s2;
    sb_if.issue_use_src2  = v.u2;
    sb_if.issue_rd_addr   = v.rd;
    sb_if.issue_writes_rd = v.wr;
    sb_if.issue_is_load   = v.ld;
    sb_if.wb_valid        = v.wv;
    sb_if.wb_addr         = v.wa;
    sb_if.xcpt_valid      = v.xv;
  endtask

  // stall is checked mid-cycle, registered outputs just after the edge
  task automatic cyc(input string nm, input logic es, input logic [31:0] eb, input logic [15:0] ec);
    @(negedge clock);
    chk({nm, "_stall"}, {31'd0, sb_if.stall_decode}, {31'd0, es});
    @(posedge clock);
    #1;
    chk({nm, "_busy"}, sb_if.busy_vec, eb);
    chk({nm, "_cnt"}, {16'd0, sb_if.stall_count}, {16'd0, ec});
  endtask

  task automatic apply(input string nm, input vec_t v);
    drive(v);
    cyc(nm, v.es, v.eb, v.ec);
  endtask

  vec_t idle;
  int   c;

  initial begin
    total = 0;
    bad   = 0;
    idle  = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 16'd0);

    //              iv    s1    s2    u2    rd    wr    ld    wv    wa    xv    es    busy          cnt
    tbl[0]  = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0000, 16'd0);
    tbl[1]  = mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0008, 16'd0);
    tbl[2]  = mk(1'b1, 5'd3, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_0008, 16'd1);
    tbl[3]  = mk(1'b1, 5'd3, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_0008, 16'd2);
    tbl[4]  = mk(1'b1, 5'd3, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 32'h0000_0000, 16'd3);
    tbl[5]  = mk(1'b1, 5'd3, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0010, 16'd3);
    tbl[6]  = mk(1'b1, 5'd0, 5'd4, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 32'h0000_0090, 16'd3);
    tbl[7]  = mk(1'b1, 5'd1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_0090, 16'd4);
    tbl[8]  = mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0091, 16'd4);
    tbl[9]  = mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_0091, 16'd5);
    tbl[10] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0000_0090, 16'd5);
    tbl[11] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 32'h0000_0080, 16'd5);
    tbl[12] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 32'h0000_0000, 16'd5);
    tbl[13] = mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0010, 16'd5);
    tbl[14] = mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0030, 16'd5);
    tbl[15] = mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0070, 16'd5);
    tbl[16] = mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_00F0, 16'd5);
    tbl[17] = mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 32'h0000_0000, 16'd5);
    tbl[18] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_0000, 16'd6);
    tbl[19] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_0000, 16'd7);
    tbl[20] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0000, 16'd7);
    tbl[21] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h0000_0000, 16'd7);
    tbl[22] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_0000, 16'd8);
    tbl[23] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 32'h0000_0000, 16'd9);
    tbl[24] = mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_0000, 16'd10);
    tbl[25] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_0000, 16'd11);
    tbl[26] = mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0000_0000, 16'd11);

    // Reset state
    reset = 1'b0;
    drive(idle);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_stall", {31'd0, sb_if.stall_decode}, 32'd0);
    chk("rst_busy", sb_if.busy_vec, 32'd0);
    chk("rst_cnt", {16'd0, sb_if.stall_count}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 27; i++) begin
      apply($sformatf("vec%0d", i), tbl[i]);
    end

    // ALU producer is bypassed only in the bypass build; loads always stall
    c = 11;
    apply("alu_r5", mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h20, 16'(c)));
    c = c + (BYP ? 0 : 1);
    apply("use_r5", mk(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, BYP ? 1'b0 : 1'b1, 32'h20, 16'(c)));
    apply("wb_r5", mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 32'h0, 16'(c)));
    apply("ldw_r6", mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h40, 16'(c)));
    apply("use_r6", mk(1'b1, 5'd0, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h40, 16'(c + 1)));
    apply("use_r6_wb", mk(1'b1, 5'd0, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b1, 32'h0, 16'(c + 2)));
    apply("use_r6_go", mk(1'b1, 5'd0, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 16'(c + 2)));
    c = c + 2;

    // Permanent hazard on r10 drives the counter into saturation
    apply("ld_r10", mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h400, 16'(c)));
    drive(mk(1'b1, 5'd10, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h400, 16'd0));
    for (int i = 0; i < 100; i++) @(posedge clock);
    #1;
    chk("sat_ramp", {16'd0, sb_if.stall_count}, 32'(c + 100));
    for (int i = 0; i < 65500; i++) @(posedge clock);
    #1;
    chk("sat_hit", {16'd0, sb_if.stall_count}, 32'h0000_FFFF);
    for (int i = 0; i < 10; i++) @(posedge clock);
    #1;
    chk("sat_hold", {16'd0, sb_if.stall_count}, 32'h0000_FFFF);
    apply("sat_wb", mk(1'b1, 5'd10, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd10, 1'b0, 1'b1, 32'h0, 16'hFFFF));
    apply("sat_go", mk(1'b1, 5'd10, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 16'hFFFF));

    // Asynchronous reset in the middle of a stall with a busy bit set
    apply("ld_r8", mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h100, 16'hFFFF));
    drive(mk(1'b1, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h100, 16'hFFFF));
    #2;
    reset = 1'b0;
    #1;
    chk("arst_stall", {31'd0, sb_if.stall_decode}, 32'd0);
    chk("arst_busy", sb_if.busy_vec, 32'd0);
    chk("arst_cnt", {16'd0, sb_if.stall_count}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    apply("post_rst", mk(1'b1, 5'd8, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h200, 16'd0));

    // Asynchronous reset in the middle of a flush
    apply("fl_x", mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h0, 16'd0));
    drive(idle);
    @(negedge clock);
    chk("fl_act", {31'd0, sb_if.stall_decode}, 32'd1);
    @(posedge clock);
    #1;
    chk("fl_cnt", {16'd0, sb_if.stall_count}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("frst_stall", {31'd0, sb_if.stall_decode}, 32'd0);
    chk("frst_cnt", {16'd0, sb_if.stall_count}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("frst_run", {31'd0, sb_if.stall_decode}, 32'd0);
    @(posedge clock);
    #1;
    apply("frst_issue", mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h2, 16'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
